// File: rtl/mips_alu_if.sv
// Operand/result bundle for the registered MIPS ALU.
// The master drives operands and the op select; the slave (the ALU) returns registered results.
interface mips_alu_if #(parameter int N = 8);
  logic         in_valid;
  logic [2:0]   F;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] y;
  logic         cout;
  logic         zero;
  logic         out_valid;

  modport master (
    output in_valid, F, a, b,
    input  y, cout, zero, out_valid
  );

  modport slave (
    input  in_valid, F, a, b,
    output y, cout, zero, out_valid
  );
endinterface

// File: rtl/mips_alu.sv
// Registered N-bit MIPS ALU: B-invert mux, ripple adder with carry-in, 4:1 result mux,
// followed by one output register stage that holds its value while in_valid is low.
module mips_alu #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            reset,
  mips_alu_if.slave       bus
);

  logic [N-1:0] bb_s;
  logic [N:0]   sum_s;
  logic [N-1:0] res_s;

  logic [N-1:0] y_d;
  logic [N-1:0] y_q;
  logic         cout_d;
  logic         cout_q;
  logic         zero_d;
  logic         zero_q;
  logic         out_valid_d;
  logic         out_valid_q;

  // Combinational core: F[2] inverts B and doubles as the adder carry-in, F[1:0] picks the result.
  always_comb begin
    bb_s  = bus.F[2] ? ~bus.b : bus.b;
    sum_s = {1'b0, bus.a} + {1'b0, bb_s} + {{N{1'b0}}, bus.F[2]};
    case (bus.F[1:0])
      2'b00:   res_s = bus.a & bb_s;
      2'b01:   res_s = bus.a | bb_s;
      2'b10:   res_s = sum_s[N-1:0];
      2'b11:   res_s = {{(N-1){1'b0}}, sum_s[N-1]};
      default: res_s = {N{1'b0}};
    endcase
  end

  // Next-state: capture the core on a valid cycle, otherwise hold; zero follows the selected result.
  always_comb begin
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      y_d    = res_s;
      cout_d = sum_s[N];
      zero_d = (res_s == {N{1'b0}});
    end else begin
      y_d    = y_q;
      cout_d = cout_q;
      zero_d = zero_q;
    end
  end

  // Output register stage with synchronous reset taking priority over in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q         <= {N{1'b0}};
      cout_q      <= 1'b0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed spec cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_mips_alu;

  localparam int N = 8;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   chk_cnt;

  mips_alu_if #(.N(N)) bus ();

  mips_alu #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, zero, y} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    int ai;
    int bi;
    int r;
    int c;
    logic [7:0] nb;
    ai = a;
    bi = b;
    nb = ~b;
    if (f < 3'd4) c = ((ai + bi) > 255) ? 1 : 0;
    else          c = (ai >= bi) ? 1 : 0;
    case (f)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = (ai + bi) % 256;
      3'd3: r = (((ai + bi) % 256) >= 128) ? 1 : 0;
      3'd4: r = a & nb;
      3'd5: r = a | nb;
      3'd6: r = (ai - bi + 256) % 256;
      default: r = (((ai - bi + 256) % 256) >= 128) ? 1 : 0;
    endcase
    model = {c[0], (r == 0), r[7:0]};
  endfunction

  task automatic issue(input logic v, input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = v;
    bus.F        = f;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    issue(1'b1, 3'd2, 8'h12, 8'h34);
    issue(1'b1, 3'd2, 8'h56, 8'h78);
    chk_cnt++;
    if ({bus.out_valid, bus.cout, bus.zero, bus.y} !== 11'b0_0_1_00000000)
      $display("FAIL reset: got ov=%b cout=%b zero=%b y=%h, want ov=0 cout=0 zero=1 y=00",
               bus.out_valid, bus.cout, bus.zero, bus.y);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_logic;
    logic [2:0] ops [4];
    logic [9:0] exp_v [4];
    ops = '{3'd0, 3'd1, 3'd4, 3'd5};
    exp_v = '{{1'b0, 1'b0, 8'h02}, {1'b0, 1'b0, 8'h03}, {1'b0, 1'b1, 8'h00}, {1'b0, 1'b0, 8'hFE}};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, ops[i], 8'h02, 8'h03);
      chk_cnt++;
      if ({bus.out_valid, bus.cout, bus.zero, bus.y} !== {1'b1, exp_v[i]})
        $display("FAIL logic F=%0d: got ov=%b cout=%b zero=%b y=%h, want ov=1 {cout,zero,y}=%h",
                 ops[i], bus.out_valid, bus.cout, bus.zero, bus.y, exp_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_arith;
    logic [2:0] ops [7];
    logic [7:0] av  [7];
    logic [7:0] bv  [7];
    logic [9:0] exp_v [7];
    ops = '{3'd2, 3'd6, 3'd7, 3'd6, 3'd7, 3'd2, 3'd7};
    av  = '{8'h02, 8'h02, 8'h02, 8'h03, 8'h03, 8'hFF, 8'h80};
    bv  = '{8'h03, 8'h03, 8'h03, 8'h02, 8'h02, 8'h01, 8'h01};
    exp_v = '{{1'b0, 1'b0, 8'h05}, {1'b0, 1'b0, 8'hFF}, {1'b0, 1'b0, 8'h01},
              {1'b1, 1'b0, 8'h01}, {1'b1, 1'b1, 8'h00}, {1'b1, 1'b1, 8'h00},
              {1'b1, 1'b1, 8'h00}};
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, ops[i], av[i], bv[i]);
      chk_cnt++;
      if ({bus.out_valid, bus.cout, bus.zero, bus.y} !== {1'b1, exp_v[i]})
        $display("FAIL arith F=%0d a=%h b=%h: got cout=%b zero=%b y=%h ov=%b, want {cout,zero,y}=%h ov=1",
                 ops[i], av[i], bv[i], bus.cout, bus.zero, bus.y, bus.out_valid, exp_v[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    issue(1'b1, 3'd2, 8'h01, 8'h01);
    chk_cnt++;
    if ({bus.out_valid, bus.cout, bus.zero, bus.y} !== 11'b1_0_0_00000010)
      $display("FAIL hold_load: got ov=%b y=%h, want ov=1 y=02", bus.out_valid, bus.y);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
      chk_cnt++;
      if ({bus.out_valid, bus.cout, bus.zero, bus.y} !== 11'b0_0_0_00000010)
        $display("FAIL hold cycle %0d: got ov=%b cout=%b zero=%b y=%h, want ov=0 cout=0 zero=0 y=02",
                 i, bus.out_valid, bus.cout, bus.zero, bus.y);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] f;
    logic [7:0] a;
    logic [7:0] b;
    logic [9:0] e;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(7));
      a = 8'($urandom);
      b = 8'($urandom);
      e = model(f, a, b);
      issue(1'b1, f, a, b);
      chk_cnt++;
      if ({bus.out_valid, bus.cout, bus.zero, bus.y} !== {1'b1, e})
        $display("FAIL b2b #%0d F=%0d a=%h b=%h: got cout=%b zero=%b y=%h ov=%b, want {cout,zero,y}=%h",
                 i, f, a, b, bus.cout, bus.zero, bus.y, bus.out_valid, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_valid;
    logic [2:0] f;
    logic [7:0] a;
    logic [7:0] b;
    logic       v;
    logic [9:0] held;
    held = {bus.cout, bus.zero, bus.y};
    held = model(3'd0, 8'h00, 8'h00);
    issue(1'b1, 3'd0, 8'h00, 8'h00);
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(1));
      f = 3'($urandom_range(7));
      a = 8'($urandom);
      b = 8'($urandom);
      if (v) held = model(f, a, b);
      issue(v, f, a, b);
      chk_cnt++;
      if ({bus.out_valid, bus.cout, bus.zero, bus.y} !== {v, held})
        $display("FAIL rand #%0d v=%b F=%0d a=%h b=%h: got ov=%b {cout,zero,y}=%h, want ov=%b %h",
                 i, v, f, a, b, bus.out_valid, {bus.cout, bus.zero, bus.y}, v, held);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream;
    issue(1'b1, 3'd2, 8'h10, 8'h20);
    reset = 1'b1;
    issue(1'b1, 3'd5, 8'h0F, 8'h0F);
    chk_cnt++;
    if ({bus.out_valid, bus.cout, bus.zero, bus.y} !== 11'b0_0_1_00000000)
      $display("FAIL reset_mid: got ov=%b cout=%b zero=%b y=%h, want ov=0 cout=0 zero=1 y=00",
               bus.out_valid, bus.cout, bus.zero, bus.y);
    else pass_cnt++;
    reset = 1'b0;
    issue(1'b1, 3'd6, 8'h09, 8'h04);
    chk_cnt++;
    if ({bus.out_valid, bus.cout, bus.zero, bus.y} !== 11'b1_1_0_00000101)
      $display("FAIL after_reset: got ov=%b cout=%b zero=%b y=%h, want ov=1 cout=1 zero=0 y=05",
               bus.out_valid, bus.cout, bus.zero, bus.y);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt     = 0;
    chk_cnt      = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.F        = 3'd0;
    bus.a        = 8'h00;
    bus.b        = 8'h00;
    test_reset;
    test_logic;
    test_arith;
    test_hold;
    test_back_to_back;
    test_random_valid;
    test_reset_midstream;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
